// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// Stage 1 forms bit and 4-bit group propagate/generate terms; stage 2 resolves all
// carries with a flattened two-level lookahead and produces sum, carry-out and overflow.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NG = WIDTH / 4;

  if (GROUP != 4) begin : g_group_chk
    $error("cla_pipe_adder: GROUP must be 4");
  end
  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_chk
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  // Stage 1 combinational terms
  logic [WIDTH-1:0]    b_eff, p_d, g_d;
  logic [NG-1:0]       gp_d, gg_d;
  logic [NG-1:0][2:0]  gl_d;
  logic                c0_d;

  // Stage 1 registers; only the low three g bits of each group are kept because the top
  // one is already folded into the group generate.
  logic                s1_valid_d, s1_valid_q;
  logic [WIDTH-1:0]    p_q;
  logic [NG-1:0][2:0]  gl_q;
  logic [NG-1:0]       gp_q, gg_q;
  logic                c0_q, a_msb_q, b_msb_q;

  // Stage 2 combinational terms and registers
  logic [NG-1:0][NG-1:0] terms;
  logic [NG:0]           gc;
  logic [WIDTH-1:0]      carry, sum_d, sum_q;
  logic                  c_out_d, c_out_q, ovf_d, ovf_q;
  logic                  s2_valid_d, s2_valid_q;

  logic s1_load, s2_load;

  assign b_eff = sub ? ~b : b;
  assign c0_d  = sub | c_in;
  assign p_d   = a ^ b_eff;
  assign g_d   = a & b_eff;

  assign gc[0] = c0_q;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int unsigned B  = 4 * k;
    // Mask of group propagates 0..k, used by the carry-in term of group carry k+1
    localparam int unsigned MC = (32'd1 << (k + 1)) - 32'd1;
    localparam logic [NG-1:0] M0 = MC[NG-1:0];

    assign gp_d[k] = &p_d[B +: 4];
    assign gg_d[k] = g_d[B+3]
                   | (p_d[B+3] & g_d[B+2])
                   | (p_d[B+3] & p_d[B+2] & g_d[B+1])
                   | (p_d[B+3] & p_d[B+2] & p_d[B+1] & g_d[B]);
    assign gl_d[k] = g_d[B +: 3];

    // Group carry k+1 as a single sum of products over all lower groups (no ripple)
    for (genvar j = 0; j < NG; j++) begin : g_term
      if (j <= k) begin : g_on
        localparam int unsigned MI = ((32'd1 << (k + 1)) - 32'd1) & ~((32'd1 << (j + 1)) - 32'd1);
        localparam logic [NG-1:0] M = MI[NG-1:0];
        assign terms[k][j] = gg_q[j] & (&(gp_q | ~M));
      end else begin : g_off
        assign terms[k][j] = 1'b0;
      end
    end
    assign gc[k+1] = (|terms[k]) | (c0_q & (&(gp_q | ~M0)));

    // In-group carries seeded by the group carry-in
    assign carry[B]   = gc[k];
    assign carry[B+1] = gl_q[k][0] | (p_q[B] & gc[k]);
    assign carry[B+2] = gl_q[k][1]
                      | (p_q[B+1] & gl_q[k][0])
                      | (p_q[B+1] & p_q[B] & gc[k]);
    assign carry[B+3] = gl_q[k][2]
                      | (p_q[B+2] & gl_q[k][1])
                      | (p_q[B+2] & p_q[B+1] & gl_q[k][0])
                      | (p_q[B+2] & p_q[B+1] & p_q[B] & gc[k]);
  end

  assign sum_d   = p_q ^ carry;
  assign c_out_d = gc[NG];
  assign ovf_d   = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);

  // Handshake: S2 advances when empty or drained; S1 advances when empty or S2 takes it
  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    in_ready   = !rst && (!s1_valid_q || s2_load);
    s1_load    = in_valid && in_ready;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  // Stage 1 state: operands captured only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      gl_q       <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        p_q     <= p_d;
        gl_q    <= gl_d;
        gp_q    <= gp_d;
        gg_q    <= gg_d;
        c0_q    <= c0_d;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b_eff[WIDTH-1];
      end
    end
  end

  // Stage 2 state: result held stable until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load && s1_valid_q) begin
        sum_q   <= sum_d;
        c_out_q <= c_out_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed 16-bit vectors, back-pressure and reset scenarios,
// then a 64-bit randomized stream scored against an arithmetic reference model.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic        ov;
    logic        co;
    logic [63:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 16-bit instance
  logic        v16, r16, ov16, or16, cin16, sub16, co16, of16;
  logic [15:0] a16, b16, s16;
  // 64-bit instance
  logic        v64, r64, ov64, or64, cin64, sub64, co64, of64;
  logic [63:0] a64, b64, s64;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v16),
    .in_ready  (r16),
    .a         (a16),
    .b         (b16),
    .c_in      (cin16),
    .sub       (sub16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (s16),
    .c_out     (co16),
    .ovf       (of16)
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(4)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v64),
    .in_ready  (r64),
    .a         (a64),
    .b         (b64),
    .c_in      (cin64),
    .sub       (sub64),
    .out_valid (ov64),
    .out_ready (or64),
    .sum       (s64),
    .c_out     (co64),
    .ovf       (of64)
  );

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic res_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic cin, input logic sub);
    logic signed [67:0] pw, half, ua, ub, sa, sb, ur, sr, ci;
    logic [63:0] mask;
    res_t r;
    pw   = 68'sd1 <<< w;
    half = pw >>> 1;
    mask = pw[63:0] - 64'd1;
    ua   = $signed({4'b0, a & mask});
    ub   = $signed({4'b0, b & mask});
    ci   = $signed({67'b0, cin});
    sa   = a[w-1] ? ua - pw : ua;
    sb   = b[w-1] ? ub - pw : ub;
    if (sub) begin
      ur   = ua - ub;
      sr   = sa - sb;
      r.co = (ua >= ub);
    end else begin
      ur   = ua + ub + ci;
      sr   = sa + sb + ci;
      r.co = (ur >= pw);
    end
    r.s  = ur[63:0] & mask;
    r.ov = (sr >= half) || (sr < -half);
    return r;
  endfunction

  function automatic logic [17:0] exp16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    res_t r;
    r = ref_model(16, {48'b0, a}, {48'b0, b}, cin, sub);
    return {r.ov, r.co, r.s[15:0]};
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  logic [17:0] q16[$];
  res_t        q64[$];
  int          cons16 = 0;
  int          cons64 = 0;
  int          acc64  = 0;
  logic        held16 = 1'b0;
  logic        held64 = 1'b0;
  logic [17:0] last16;
  logic [65:0] last64;
  logic        saw_stall;

  // 16-bit scoreboard: in-order results and stability while stalled
  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      held16 = 1'b0;
    end else begin
      if (held16) check_eq("hold16", {ov16, of16, co16, s16}, {1'b1, last16});
      if (ov16 && or16) begin
        if (q16.size() == 0) begin
          check_eq("spurious16", ov16, 1'b0);
        end else begin
          check_eq("res16", {of16, co16, s16}, q16.pop_front());
          cons16++;
        end
      end
      held16 = ov16 && !or16;
      last16 = {of16, co16, s16};
    end
  end

  // 64-bit scoreboard: model values pushed on accept, compared on consume
  always @(negedge clk) begin
    if (rst) begin
      q64.delete();
      held64 = 1'b0;
    end else begin
      if (held64) check_eq("hold64", {of64, co64, s64}, last64);
      if (ov64 && or64) begin
        if (q64.size() == 0) begin
          check_eq("spurious64", ov64, 1'b0);
        end else begin
          check_eq("res64", {of64, co64, s64}, q64.pop_front());
          cons64++;
        end
      end
      if (v64 && r64) begin
        q64.push_back(ref_model(64, a64, b64, cin64, sub64));
        acc64++;
      end
      held64 = ov64 && !or64;
      last64 = {of64, co64, s64};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [17:0] exp);
    logic got;
    got   = 1'b0;
    v16   = 1'b1;
    a16   = a;
    b16   = b;
    cin16 = cin;
    sub16 = sub;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (r16) got = 1'b1;
    end
    check_eq("accept16", got, 1'b1);
    if (got) q16.push_back(exp);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    a16 = 'x;
    b16 = 'x;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c_start;
    logic [15:0] ra, rb;
    logic        rc, rs;

    rst = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    v64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; or64 = 1'b1;

    #12;
    check_eq("rst_out_valid", ov16, 1'b0);
    check_eq("rst_sum", s16, 16'h0);
    check_eq("rst_c_out", co16, 1'b0);
    check_eq("rst_ovf", of16, 1'b0);
    check_eq("rst_in_ready", r16, 1'b0);
    check_eq("rst_out_valid64", ov64, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", r16, 1'b1);
    @(posedge clk);
    #1;

    // Basic add with two-cycle latency
    send16(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
    @(negedge clk);
    check_eq("lat_cycle1", ov16, 1'b0);
    @(negedge clk);
    check_eq("lat_cycle2", ov16, 1'b1);
    @(posedge clk);
    #1;

    // Wrap-around, signed overflow, subtract with ignored carry-in
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send16(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      send16(ra, rb, rc, rs, exp16(ra, rb, rc, rs));
    end
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure: out_ready low for cycles 3-6 of a 5-beat stream
    c_start   = cons16;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
          send16(ra, rb, rc, rs, exp16(ra, rb, rc, rs));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        or16 = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!r16) saw_stall = 1'b1;
        end
        @(posedge clk);
        #1;
        or16 = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check_eq("bp_in_ready_low", saw_stall, 1'b1);
    check_eq("bp_count", cons16 - c_start, 5);
    check_eq("bp_queue_empty", q16.size(), 0);

    // Asynchronous reset with two beats in flight
    or16 = 1'b0;
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, exp16(16'h1111, 16'h2222, 1'b0, 1'b0));
    send16(16'h3333, 16'h4444, 1'b0, 1'b0, exp16(16'h3333, 16'h4444, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", ov16, 1'b0);
    check_eq("rst_async_sum", s16, 16'h0);
    check_eq("rst_async_in_ready", r16, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst  = 1'b0;
    or16 = 1'b1;
    c_start = cons16;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_no_stale", cons16 - c_start, 0);
    send16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});
    @(negedge clk);
    check_eq("rst_lat_cycle1", ov16, 1'b0);
    @(negedge clk);
    check_eq("rst_lat_cycle2", ov16, 1'b1);
    @(posedge clk);
    #1;

    // 64-bit randomized stream with random back-pressure
    for (int cyc = 0; cyc < 40000 && acc64 < 10000; cyc++) begin
      v64   = ($urandom_range(3) != 0);
      a64   = rnd64();
      b64   = rnd64();
      cin64 = 1'($urandom_range(1));
      sub64 = 1'($urandom_range(1));
      or64  = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    v64  = 1'b0;
    or64 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("rnd_accepts", acc64, 10000);
    check_eq("rnd_consumed", cons64, acc64);
    check_eq("rnd_queue_empty", q64.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Successor to the single 4-bit lookahead carry unit.
- Generalised to WIDTH bits as 4-bit lookahead groups plus a second-level group lookahead.
- Adds a subtract mode, carry/overflow flags and a valid/ready stream handshake with back-pressure.
- Sits between operand-issue logic and the result writeback path of the datapath.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and in the range 4..64.
- GROUP, 4, bits per lookahead group; fixed at 4; any other value is a synthesis-time error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+c_in; 1: A-B, computed as A+~B+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: both stage-valid flags clear, so out_valid=0, sum=0, c_out=0, ovf=0. in_ready=1 whenever rst=0 and stage 1 can advance.
- Stage 1 (S1), registered on the accept edge:
  - Effective B: b_eff = sub ? ~b : b. Effective carry-in: c0 = sub ? 1 : c_in.
  - Per bit: p[i] = a[i]^b_eff[i], g[i] = a[i]&b_eff[i].
  - Per group k: P_k = AND of its four p. G_k = g3|p3g2|p3p2g1|p3p2p1g0.
  - Register p, g, P, G, c0 and the MSBs a[W-1] and b_eff[W-1].
- Stage 2 (S2), registered:
  - Group carries: C_0 = c0; C_{k+1} = G_k | P_k&C_k, flattened as a lookahead over all groups (no ripple chain across groups).
  - In-group carries use the 4-bit lookahead equations seeded by C_k.
  - sum[i] = p[i] ^ carry[i]. c_out = C_{WIDTH/4}.
  - ovf = (a_msb == b_eff_msb) && (sum[W-1] != a_msb).
- Latency: 2 cycles from accept to out_valid when there is no stall. Throughput: 1 beat per cycle.
- Handshake:
  - Input is accepted on in_valid&in_ready. Output is consumed on out_valid&out_ready.
  - S2 loads when S2 is empty or out_ready=1.
  - in_ready = !S1_valid | S2 loads this cycle. Bubbles collapse: an empty S2 absorbs S1 even while out_ready=0.
  - With out_ready=0 and both stages full: in_ready=0; sum, c_out and ovf stay stable.
  - Once out_valid is high, the output must not change until consumed.
  - Simultaneous accept and consume in the same cycle is allowed with no lost or duplicated beat.
  - in_valid may drop without being accepted; a, b and sub are sampled only on accept.
- Wrap-around: the sum is modulo 2^WIDTH. All-ones + 1 gives sum=0 and c_out=1.
- Reset mid-operation: in-flight beats are discarded. No output beat appears after reset deassertion until a new accept.
- X on a or b while in_valid=0 must not propagate into the valid flags.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, c_in=1, sub=0, out_ready=1 -> after 2 cycles out_valid=1, sum=0x5556, c_out=0, ovf=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, c_in=1 (must be ignored) -> sum=0xFFFE, c_out=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Back-pressure: stream 5 beats with out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full. All 5 results appear in order, none lost or duplicated, and the output stays stable while stalled.
- Assert rst while 2 beats are in flight -> out_valid=0 and sum=0 immediately (asynchronous). After release, no stale beat appears; the next accept yields a correct result 2 cycles later.
- WIDTH=64, 10,000 random a/b/c_in/sub with random out_ready -> every result matches a reference A±B model, including c_out and ovf.
